// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader
// Walks register-file addresses 0..NUM_REGS-1 through a shared read port and
// streams each word out on a valid/ready interface, tagged with its address
// and a last flag.
// Ports:
//   clk, rst               clock and synchronous active-high reset
//   start, abort           begin a dump (IDLE only) / cancel from any state
//   rf_req, rf_gnt         read-port request and grant
//   rf_raddr, rf_rdata     read address out, combinational read data in
//   out_valid, out_ready   output stream handshake
//   out_data, out_addr     captured word and its address
//   out_last               marks the word for address NUM_REGS-1
//   busy, done             activity flag, one-cycle end-of-dump pulse
module regfile_dump_reader #(
    parameter int unsigned NUM_REGS   = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    output logic                  rf_req,
    input  logic                  rf_gnt,
    output logic [ADDR_WIDTH-1:0] rf_raddr,
    input  logic [DATA_WIDTH-1:0] rf_rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_REGS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_HOLD = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e                  state_q,     state_d;
    logic [ADDR_WIDTH-1:0]   addr_q,      addr_d;
    logic                    rf_req_q,    rf_req_d;
    logic [ADDR_WIDTH-1:0]   rf_raddr_q,  rf_raddr_d;
    logic                    out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]   out_data_q,  out_data_d;
    logic [ADDR_WIDTH-1:0]   out_addr_q,  out_addr_d;
    logic                    out_last_q,  out_last_d;
    logic                    busy_q,      busy_d;
    logic                    done_q,      done_d;

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_addr_d  = out_addr_q;
        out_last_d  = out_last_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_READ;
                    addr_d  = '0;
                end
            end
            S_READ: begin
                if (rf_gnt) begin
                    out_data_d  = rf_rdata;
                    out_addr_d  = addr_q;
                    out_last_d  = (addr_q == LAST_ADDR);
                    out_valid_d = 1'b1;
                    state_d     = S_HOLD;
                end
            end
            S_HOLD: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    if (out_last_q) begin
                        state_d = S_DONE;
                    end else begin
                        addr_d  = addr_q + ADDR_WIDTH'(1);
                        state_d = S_READ;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Cancel wins over every other event in the same cycle
        if (abort) begin
            state_d     = S_IDLE;
            addr_d      = '0;
            out_valid_d = 1'b0;
        end

        // Status outputs are registered copies of what the next state implies
        rf_req_d   = (state_d == S_READ);
        rf_raddr_d = rf_req_d ? addr_d : '0;
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            rf_req_q    <= 1'b0;
            rf_raddr_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rf_req_q    <= rf_req_d;
            rf_raddr_q  <= rf_raddr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign rf_req    = rf_req_q;
    assign rf_raddr  = rf_raddr_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_addr  = out_addr_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// tb_regfile_dump_reader
// Directed bench for regfile_dump_reader. A small register-file array feeds
// rf_rdata; a per-cycle checker compares the DUT against expected words and
// handshake timing, and directed sequences pin latencies and counts.
module tb_regfile_dump_reader;

    logic        clk = 1'b0;
    logic        rst, start, abort, rf_gnt, out_ready;
    logic        rf_req, out_valid, out_last, busy, done;
    logic [4:0]  rf_raddr, out_addr;
    logic [31:0] rf_rdata, out_data;
    logic [31:0] regs [32];

    always #5 clk = ~clk;

    assign rf_rdata = regs[rf_raddr];

    regfile_dump_reader #(.NUM_REGS(32), .ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .rf_req(rf_req), .rf_gnt(rf_gnt), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_addr(out_addr), .out_last(out_last), .busy(busy), .done(done)
    );

    int n_cmp = 0;
    int n_err = 0;
    int exp_idx = 0;
    int n_done = 0;
    int n_stall = 0;
    int n_hold = 0;
    int cyc = 0;
    int first_req_cyc = 0;
    int done_cyc = 0;
    logic [31:0] acc_q [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Values seen on the previous falling edge (i.e. what the DUT sampled)
    logic p_kill = 1'b1, p_rst = 1'b1;
    logic p_start_idle = 1'b0, p_req = 1'b0, p_gnt = 1'b0;
    logic p_valid = 1'b0, p_ready = 1'b0, p_last = 1'b0;
    logic p_acc_last = 1'b0, p_acc_more = 1'b0, p_done = 1'b0;
    logic [31:0] p_data = '0;
    logic [4:0]  p_addr = '0;

    // Per-cycle checker and scoreboard
    always @(negedge clk) begin
        cyc++;
        if (p_kill) begin
            chk("kill_busy", 32'(busy), 0);
            chk("kill_valid", 32'(out_valid), 0);
            chk("kill_req", 32'(rf_req), 0);
            chk("kill_done", 32'(done), 0);
            if (p_rst) begin
                chk("rst_data", out_data, 0);
                chk("rst_addr", 32'(out_addr), 0);
                chk("rst_last", 32'(out_last), 0);
                chk("rst_raddr", 32'(rf_raddr), 0);
            end
            exp_idx = 0;
        end else begin
            if (p_start_idle) begin
                chk("start_req", 32'(rf_req), 1);
                chk("start_busy", 32'(busy), 1);
                first_req_cyc = cyc;
            end
            if (rf_req) begin
                chk("req_raddr", 32'(rf_raddr), 32'(exp_idx));
                chk("req_no_valid", 32'(out_valid), 0);
            end
            if (p_req && !p_gnt)
                chk("stall_keeps_req", 32'(rf_req), 1);
            if (p_req && p_gnt)
                chk("grant_to_valid", 32'(out_valid), 1);
            if (p_valid && !p_ready) begin
                chk("hold_valid", 32'(out_valid), 1);
                chk("hold_data", out_data, p_data);
                chk("hold_addr", 32'(out_addr), 32'(p_addr));
                chk("hold_last", 32'(out_last), 32'(p_last));
                chk("hold_no_req", 32'(rf_req), 0);
            end
            if (p_acc_more)
                chk("accept_to_req", 32'(rf_req), 1);
            if (p_acc_last)
                chk("last_to_done", 32'(done), 1);
            if (p_done)
                chk("done_then_idle", 32'(busy), 0);
            if (out_valid) begin
                chk("word_addr", 32'(out_addr), 32'(exp_idx));
                chk("word_data", out_data, regs[exp_idx[4:0]]);
                chk("word_last", 32'(out_last), 32'(exp_idx == 31));
            end
            if (rf_req || out_valid || done)
                chk("busy_when_active", 32'(busy), 1);
            if (!busy) begin
                chk("idle_req", 32'(rf_req), 0);
                chk("idle_valid", 32'(out_valid), 0);
            end
            if (done) begin
                chk("done_after_all", 32'(exp_idx), 32);
                n_done++;
                done_cyc = cyc;
                exp_idx = 0;
            end
        end

        if (rf_req && !rf_gnt) n_stall++;
        if (out_valid && !out_ready) n_hold++;

        p_acc_last = 1'b0;
        p_acc_more = 1'b0;
        if (out_valid && out_ready && !abort && !rst) begin
            acc_q.push_back(out_data);
            p_acc_last = (exp_idx == 31);
            p_acc_more = (exp_idx != 31);
            exp_idx++;
        end
        p_kill       = rst || abort;
        p_rst        = rst;
        p_start_idle = start && !busy && !rst && !abort;
        p_req        = rf_req && !rst && !abort;
        p_gnt        = rf_gnt;
        p_valid      = out_valid && !rst && !abort;
        p_ready      = out_ready;
        p_data       = out_data;
        p_addr       = out_addr;
        p_last       = out_last;
        p_done       = done && !rst && !abort;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // kind 0: read of address a; kind 1: word a on output; kind 2: done
    task automatic wait_for(input int kind, input int a, input string nm);
        logic hit = 1'b0;
        for (int n = 0; n < 300 && !hit; n++) begin
            @(negedge clk);
            case (kind)
                0:       hit = rf_req && (32'(rf_raddr) == a);
                1:       hit = out_valid && (32'(out_addr) == a);
                default: hit = done;
            endcase
        end
        if (!hit) begin
            n_cmp++;
            n_err++;
            $display("FAIL timeout %s: condition not reached within 300 cycles", nm);
        end
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 32; k++)
            regs[k] = (k == 0) ? 32'h0 : 32'hA500_0000 + 32'(k);
        rst = 1'b1; start = 1'b0; abort = 1'b0; rf_gnt = 1'b1; out_ready = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        step();

        // Full dump at best-case throughput
        acc_q.delete();
        start = 1'b1; step(); start = 1'b0;
        wait_for(2, 0, "dump1_done");
        chk("dump1_words", 32'(acc_q.size()), 32);
        chk("dump1_w0", acc_q[0], 32'h0000_0000);
        chk("dump1_w7", acc_q[7], 32'hA500_0007);
        chk("dump1_w31", acc_q[31], 32'hA500_001F);
        chk("dump1_done_latency", 32'(done_cyc - first_req_cyc), 64);
        chk("dump1_ndone", 32'(n_done), 1);
        repeat (2) step();

        // Grant stall at 7, ignored start at 10, back-pressure at 12
        acc_q.delete();
        n_stall = 0;
        start = 1'b1; step(); start = 1'b0;
        wait_for(1, 6, "dump2_word6");
        rf_gnt = 1'b0;
        repeat (3) step();
        rf_gnt = 1'b1;
        chk("dump2_stall_cycles", 32'(n_stall), 3);
        wait_for(0, 10, "dump2_read10");
        start = 1'b1; step(); start = 1'b0;
        wait_for(0, 12, "dump2_read12");
        n_hold = 0;
        out_ready = 1'b0;
        repeat (5) step();
        out_ready = 1'b1;
        chk("dump2_hold_cycles", 32'(n_hold), 5);
        wait_for(2, 0, "dump2_done");
        chk("dump2_words", 32'(acc_q.size()), 32);
        chk("dump2_w7", acc_q[7], 32'hA500_0007);
        chk("dump2_w8", acc_q[8], 32'hA500_0008);
        chk("dump2_w12", acc_q[12], 32'hA500_000C);
        chk("dump2_ndone", 32'(n_done), 2);
        repeat (2) step();

        // Abort while word 20 is pending
        acc_q.delete();
        start = 1'b1; step(); start = 1'b0;
        wait_for(0, 20, "dump3_read20");
        out_ready = 1'b0;
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        out_ready = 1'b1;
        repeat (3) step();
        chk("abort_busy", 32'(busy), 0);
        chk("abort_words", 32'(acc_q.size()), 20);
        chk("abort_ndone", 32'(n_done), 2);

        // Fresh dump after abort restarts from address 0
        acc_q.delete();
        start = 1'b1; step(); start = 1'b0;
        wait_for(2, 0, "dump4_done");
        chk("dump4_words", 32'(acc_q.size()), 32);
        chk("dump4_w0", acc_q[0], 32'h0000_0000);
        chk("dump4_w1", acc_q[1], 32'hA500_0001);
        chk("dump4_ndone", 32'(n_done), 3);
        repeat (2) step();

        // Reset mid-dump dominates abort and start
        start = 1'b1; step(); start = 1'b0;
        wait_for(0, 5, "dump5_read5");
        rst = 1'b1; abort = 1'b1; start = 1'b1;
        step();
        rst = 1'b0; abort = 1'b0; start = 1'b0;
        repeat (3) step();
        chk("rst_busy_after", 32'(busy), 0);
        chk("rst_req_after", 32'(rf_req), 0);
        chk("rst_ndone", 32'(n_done), 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
